// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: I2C master byte sequencer (START/WRITE/READ/STOP) driving open-drain pull-low enables.
// Optional I2C_CLK_STRETCH_EN: hold the quarter counter while a released SCL is still held low.
module i2c_byte_ctrl (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic [2:0] sppr_in,
  input  logic [2:0] spr_in,
  input  logic       cmd_valid_in,
  output logic       cmd_ready,
  input  logic [1:0] cmd_in,
  input  logic [7:0] wdata_in,
  input  logic       mack_in,
  output logic       done_out,
  output logic [7:0] rdata_out,
  output logic       ack_out,
  output logic       busy_out,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] C_START = 2'd0, C_WRITE = 2'd1, C_READ = 2'd2, C_STOP = 2'd3;
  state_t state;
  logic [1:0] cmd_r, phase, e_cmd, e_ph;
  logic [3:0] bit_idx, e_bit;
  logic [11:0] cnt, qm1, q_in_m1;
  logic [7:0] wdata_r, e_wd, shift_r;
  logic mack_r, e_mk, ack_r, bit_lvl, scl_n, sda_n, hold, is_bit, acc;
  assign acc = state == IDLE;
  assign is_bit = cmd_r == C_WRITE || cmd_r == C_READ;
  assign q_in_m1 = (({9'd0, sppr_in} + 12'd1) << spr_in) - 12'd1;
`ifdef I2C_CLK_STRETCH_EN
  assign hold = !scl_oe && cnt == 12'd0 && !scl_in;
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold = 1'b0;
`endif
  // Line levels for the phase about to be entered (first phase on accept, else the next one).
  always_comb begin
    e_cmd = acc ? cmd_in : cmd_r;
    e_wd = acc ? wdata_in : wdata_r;
    e_mk = acc ? mack_in : mack_r;
    e_ph = acc ? 2'd0 : phase + 2'd1;
    e_bit = acc ? 4'd0 : (phase == 2'd3 ? bit_idx + 4'd1 : bit_idx);
    bit_lvl = e_bit[3] ? (e_cmd == C_READ && !e_mk) : (e_cmd == C_WRITE && !e_wd[3'd7 - e_bit[2:0]]);
    scl_n = scl_oe;
    sda_n = sda_oe;
    if (e_cmd == C_START) begin
      if (e_ph == 2'd0) sda_n = 1'b0;
      else if (e_ph == 2'd1) scl_n = 1'b0;
      else if (e_ph == 2'd2) sda_n = 1'b1;
      else scl_n = 1'b1;
    end else if (e_cmd == C_STOP) begin
      if (e_ph == 2'd0) begin
        scl_n = 1'b1;
        sda_n = 1'b1;
      end else if (e_ph == 2'd1) scl_n = 1'b0;
      else if (e_ph == 2'd3) sda_n = 1'b0;
    end else begin
      scl_n = e_ph < 2'd2;
      if (e_ph == 2'd0) sda_n = bit_lvl;
    end
  end
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      done_out <= 1'b0;
      rdata_out <= '0;
      ack_out <= 1'b0;
      busy_out <= 1'b0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
      cmd_r <= '0;
      phase <= '0;
      bit_idx <= '0;
      cnt <= '0;
      qm1 <= '0;
      wdata_r <= '0;
      mack_r <= 1'b0;
      shift_r <= '0;
      ack_r <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: if (cmd_valid_in) begin
          state <= RUN;
          cmd_ready <= 1'b0;
          cmd_r <= cmd_in;
          wdata_r <= wdata_in;
          mack_r <= mack_in;
          qm1 <= q_in_m1;
          cnt <= '0;
          phase <= '0;
          bit_idx <= '0;
          scl_oe <= scl_n;
          sda_oe <= sda_n;
        end
        RUN: if (!hold) begin
          if (cnt != qm1) cnt <= cnt + 12'd1;
          else begin
            cnt <= '0;
            phase <= phase + 2'd1;
            if (is_bit && phase == 2'd2) begin
              if (bit_idx[3]) ack_r <= sda_in;
              else shift_r <= {shift_r[6:0], sda_in};
            end
            // After the 9th bit SCL is parked low so the next byte can start cleanly.
            if (phase == 2'd3 && (!is_bit || bit_idx[3])) begin
              state <= DONE;
              scl_oe <= is_bit | scl_oe;
            end else begin
              scl_oe <= scl_n;
              sda_oe <= sda_n;
              if (phase == 2'd3) bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
          done_out <= 1'b1;
          if (is_bit) ack_out <= ack_r;
          if (cmd_r == C_READ) rdata_out <= shift_r;
          if (cmd_r == C_START) busy_out <= 1'b1;
          else if (cmd_r == C_STOP) busy_out <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// tb_i2c_byte_ctrl: randomized bench with a bus-level slave model and per-command expectations.
module tb_i2c_byte_ctrl;
  logic clk_in = 1'b0, rstn_in = 1'b1;
  logic [2:0] sppr_in = '0, spr_in = '0;
  logic cmd_valid_in = 1'b0, mack_in = 1'b0;
  logic [1:0] cmd_in = '0;
  logic [7:0] wdata_in = '0;
  logic cmd_ready, done_out, ack_out, busy_out, scl_oe, sda_oe, scl_in, sda_in;
  logic [7:0] rdata_out;
  int n_vec = 0, n_err = 0;
  logic [1:0] s_mode = '0;
  logic [7:0] s_byte = '0;
  logic s_ack = 1'b0, stretch = 1'b0, prev_oe = 1'b0, pull;
  logic [8:0] s_seen = '0;
  int s_rises = 0, s_falls = 0, st_cnt = 0, stretch_at = -1;
  logic exp_busy = 1'b0, exp_ack = 1'b0;
  logic [7:0] exp_rdata = '0;

  i2c_byte_ctrl dut (.clk_in(clk_in), .rstn_in(rstn_in), .sppr_in(sppr_in), .spr_in(spr_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready(cmd_ready), .cmd_in(cmd_in), .wdata_in(wdata_in),
    .mack_in(mack_in), .done_out(done_out), .rdata_out(rdata_out), .ack_out(ack_out),
    .busy_out(busy_out), .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe));

  always #5 clk_in = ~clk_in;

  // Slave: drives read data while SCL is low, ACKs the 9th bit of a write, may stretch SCL.
  always_comb pull = (s_mode == 2'd2 && s_falls < 8) ? ~s_byte[3'(7 - s_falls)] : (s_mode == 2'd1 && s_falls == 8 && s_ack);
  assign sda_in = ~(sda_oe | pull);
  assign scl_in = ~(scl_oe | stretch);

  always @(negedge clk_in) begin
    prev_oe <= scl_oe;
    if (cmd_ready) begin
      s_rises <= 0;
      s_falls <= 0;
    end else begin
      if (prev_oe && !scl_oe) begin
        if (s_rises < 9) s_seen[4'(8 - s_rises)] <= sda_in;
        s_rises <= s_rises + 1;
        if (s_rises == stretch_at) stretch <= 1'b1;
      end
      if (!prev_oe && scl_oe && s_rises > 0) s_falls <= s_falls + 1;
    end
    if (stretch && st_cnt == 20) stretch <= 1'b0;
  end
  always @(posedge clk_in) st_cnt <= stretch ? st_cnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [2:0] pp, input logic [2:0] sp,
                         input logic [7:0] wd, input logic mk, input logic [7:0] rb,
                         input logic ak, input int extra);
    int q, n, k, first_sda;
    q = (int'(pp) + 1) << sp;
    n = (c == 2'd1 || c == 2'd2) ? 36 : 4;
    s_mode = (c == 2'd1) ? 2'd1 : (c == 2'd2) ? 2'd2 : 2'd0;
    s_byte = rb;
    s_ack = ak;
    @(negedge clk_in);
    chk("ready_idle", cmd_ready, 1);
    sppr_in = pp; spr_in = sp; cmd_in = c; wdata_in = wd; mack_in = mk; cmd_valid_in = 1'b1;
    @(posedge clk_in); #1;
    chk("ready_run", cmd_ready, 0);
    cmd_in = 2'($urandom); wdata_in = 8'($urandom); sppr_in = 3'($urandom); spr_in = 3'($urandom); mack_in = 1'($urandom);
    k = 0;
    first_sda = -1;
    do begin
      @(posedge clk_in); #1;
      k++;
      if (sda_oe && first_sda < 0) first_sda = k;
    end while (!done_out && k < 5000);
    cmd_valid_in = 1'b0;
    chk("latency", k, n * q + 1 + extra);
    if (c == 2'd0) begin
      exp_busy = 1'b1;
      chk("start_sda_fall_time", first_sda, 2 * q);
      chk("start_lines", {scl_oe, sda_oe}, 2'b11);
    end else if (c == 2'd3) begin
      exp_busy = 1'b0;
      chk("stop_lines", {scl_oe, sda_oe}, 2'b00);
    end else if (c == 2'd1) begin
      exp_ack = ~ak;
      chk("write_bits_on_bus", s_seen, {wd, ~ak});
      chk("write_lines", {scl_oe, sda_oe}, 2'b10);
    end else begin
      exp_ack = mk;
      exp_rdata = rb;
      chk("read_bits_on_bus", s_seen, {rb, mk});
      chk("read_lines", {scl_oe, sda_oe}, {1'b1, ~mk});
    end
    chk("busy", busy_out, exp_busy);
    chk("ack", ack_out, exp_ack);
    chk("rdata", rdata_out, exp_rdata);
    @(posedge clk_in); #1;
    chk("done_pulse", done_out, 0);
  endtask

  initial begin
    int k, stretch_extra;
    logic [1:0] c;
    #2 rstn_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rstn_in = 1'b1;
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done_out, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_lines", {scl_oe, sda_oe}, 2'b00);
    run_cmd(2'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    run_cmd(2'd1, 3'd1, 3'd1, 8'hA5, 1'b0, 8'h00, 1'b1, 0);
    run_cmd(2'd2, 3'd0, 3'd0, 8'h00, 1'b1, 8'h3C, 1'b0, 0);
    run_cmd(2'd1, 3'd0, 3'd1, 8'h5A, 1'b0, 8'h00, 1'b0, 0);
    run_cmd(2'd3, 3'd0, 3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 0);
`ifdef I2C_CLK_STRETCH_EN
    stretch_extra = 20;
`else
    stretch_extra = 0;
`endif
    run_cmd(2'd0, 3'd1, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    stretch_at = 3;
    run_cmd(2'd1, 3'd1, 3'd0, 8'hC3, 1'b0, 8'h00, 1'b1, stretch_extra);
    stretch_at = -1;
    run_cmd(2'd3, 3'd1, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    for (int r = 0; r < 8; r++) begin
      run_cmd(2'd0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 2)), 8'h00, 1'b0, 8'h00, 1'b0, 0);
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        c = $urandom_range(0, 1) ? 2'd1 : 2'd2;
        run_cmd(c, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 2)), 8'($urandom), 1'($urandom),
                8'($urandom), 1'($urandom), 0);
      end
      run_cmd(2'd3, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 2)), 8'h00, 1'b0, 8'h00, 1'b0, 0);
    end
    run_cmd(2'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    s_mode = 2'd1; s_byte = 8'h00; s_ack = 1'b1;
    @(negedge clk_in);
    cmd_in = 2'd1; wdata_in = 8'hFF; sppr_in = 3'd0; spr_in = 3'd1; cmd_valid_in = 1'b1;
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b0;
    k = 0;
    while (s_falls < 4 && k < 1000) begin
      @(posedge clk_in); #1;
      k++;
    end
    chk("reach_bit4", k < 1000, 1);
    #2 rstn_in = 1'b0;
    #1;
    chk("midrst_lines", {scl_oe, sda_oe}, 2'b00);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy", busy_out, 0);
    @(negedge clk_in) rstn_in = 1'b1;
    exp_busy = 1'b0; exp_ack = 1'b0; exp_rdata = 8'h00;
    run_cmd(2'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
